// File: rtl/uart_word_tx_arbiter_if.sv
// Requester / word-transmitter bundle of the UART word transmit arbiter.
// The master modport is the arbiter view; the slave modport is the environment view.
interface uart_word_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  tx_start;
    logic [31:0]           tx_data;
    logic                  tx_done;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_clear;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_done,
        input  err_clear,
        output req_ack,
        output tx_start,
        output tx_data,
        output grant_id,
        output busy,
        output err_timeout
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_done,
        output err_clear,
        input  req_ack,
        input  tx_start,
        input  tx_data,
        input  grant_id,
        input  busy,
        input  err_timeout
    );
endinterface

// File: rtl/uart_word_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit UART word transmitter between NUM_REQ requesters,
// with a latched word, an optional inter-word gap and a watchdog on the transmitter handshake.
module uart_word_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_word_tx_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GW-1:0] PTR_LAST = GW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   GAP_LAST = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // First set bit at or above ptr, wrapping; result is {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [GW-1:0]      ptr);
        logic          found;
        logic [GW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[k]) begin
                found = 1'b1;
                idx   = GW'(k);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [31:0] word_of(input logic [32*NUM_REQ-1:0] data,
                                            input logic [GW-1:0]        idx);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == idx) begin
                w = data[32*i +: 32];
            end
        end
        return w;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [GW-1:0]      rr_ptr_r;
    logic [GW-1:0]      rr_ptr_nxt_s;
    logic [NUM_REQ-1:0] ack_r;
    logic [NUM_REQ-1:0] ack_nxt_s;
    logic               start_r;
    logic               start_nxt_s;
    logic [31:0]        data_r;
    logic [31:0]        data_nxt_s;
    logic [GW-1:0]      grant_r;
    logic [GW-1:0]      grant_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic [TW-1:0]      to_cnt_r;
    logic [TW-1:0]      to_cnt_nxt_s;
    logic [15:0]        gap_cnt_r;
    logic [15:0]        gap_cnt_nxt_s;
    logic [GW:0]        pick_s;
    logic               found_s;
    logic [GW-1:0]      pick_idx_s;

    // State and all output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            ack_r     <= '0;
            start_r   <= 1'b0;
            data_r    <= 32'd0;
            grant_r   <= '0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            to_cnt_r  <= '0;
            gap_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            ack_r     <= ack_nxt_s;
            start_r   <= start_nxt_s;
            data_r    <= data_nxt_s;
            grant_r   <= grant_nxt_s;
            busy_r    <= busy_nxt_s;
            err_r     <= err_nxt_s;
            to_cnt_r  <= to_cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        pick_s     = rr_pick(bus.req_valid, rr_ptr_r);
        found_s    = pick_s[GW];
        pick_idx_s = pick_s[GW-1:0];

        state_nxt_s   = state_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        ack_nxt_s     = '0;
        start_nxt_s   = 1'b0;
        data_nxt_s    = data_r;
        grant_nxt_s   = grant_r;
        to_cnt_nxt_s  = to_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        // A timeout on the same edge as err_clear must still leave the flag set.
        err_nxt_s     = bus.err_clear ? 1'b0 : err_r;

        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    data_nxt_s   = word_of(bus.req_data, pick_idx_s);
                    grant_nxt_s  = pick_idx_s;
                    ack_nxt_s    = NUM_REQ'(1) << pick_idx_s;
                    rr_ptr_nxt_s = (pick_idx_s == PTR_LAST) ? GW'(0) : (pick_idx_s + GW'(1));
                    state_nxt_s  = ST_START;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_START: begin
                start_nxt_s  = 1'b1;
                to_cnt_nxt_s = '0;
                state_nxt_s  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a watchdog expiring on the same edge.
                if (bus.tx_done) begin
                    gap_cnt_nxt_s = 16'd0;
                    state_nxt_s   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else if (to_cnt_r == TO_LAST) begin
                    err_nxt_s     = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    to_cnt_nxt_s  = to_cnt_r + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s   = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    assign bus.req_ack     = ack_r;
    assign bus.tx_start    = start_r;
    assign bus.tx_data     = data_r;
    assign bus.grant_id    = grant_r;
    assign bus.busy        = busy_r;
    assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// Randomized scoreboard bench for uart_word_tx_arbiter: a set-based round-robin model predicts
// grants, a transmitter model schedules busy/error expectations, and a monitor compares them.
module tb_uart_word_tx_arbiter;
    localparam int N    = 4;
    localparam int GAP  = 5;
    localparam int TO   = 16;
    localparam int HANG = 100;

    typedef struct {
        int          idx;
        logic [31:0] word;
    } grant_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_word_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_word_tx_arbiter #(
        .NUM_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    grant_t      exp_q[$];
    logic        exp_busy[int];
    logic        exp_err[int];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          model_ptr = 0;
    logic        model_err = 1'b0;
    logic [31:0] cur_word = 32'd0;
    int          next_start_min = 0;
    int          ack_cyc = -10;
    int          force_d = -1;
    logic        cont_mode = 1'b0;
    int          cont_left = 0;
    logic [31:0] words[N];
    grant_t      mon_e;
    int          tx_c, tx_d, tx_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the grant scoreboard and checks scheduled timing expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.req_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 64'(bus.req_ack), 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("ack_vector", 64'(bus.req_ack), 64'd1 << mon_e.idx);
                        check("grant_data", 64'(bus.tx_data), 64'(mon_e.word));
                        check("grant_id", 64'(bus.grant_id), 64'(mon_e.idx));
                        cur_word = mon_e.word;
                    end
                    ack_cyc = cyc;
                end else begin
                    check("tx_data_hold", 64'(bus.tx_data), 64'(cur_word));
                end
                check("start_latency", 64'(bus.tx_start), 64'(cyc == ack_cyc + 1));
                if (bus.tx_start) begin
                    check("start_spacing", 64'(cyc >= next_start_min), 64'd1);
                end
                if (exp_busy.exists(cyc)) begin
                    check("busy", 64'(bus.busy), 64'(exp_busy[cyc]));
                    exp_busy.delete(cyc);
                end
                if (exp_err.exists(cyc)) begin
                    check("err_timeout", 64'(bus.err_timeout), 64'(exp_err[cyc]));
                    exp_err.delete(cyc);
                end
            end
        end
    end

    // Transmitter model: answers each tx_start after d cycles, or never (watchdog case).
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.tx_start) begin
                #1;
                tx_c = cyc;
                if (force_d >= 0) begin
                    tx_d = force_d;
                end else begin
                    tx_r = $urandom_range(0, 19);
                    tx_d = (tx_r <= 15) ? tx_r : (HANG + tx_r);
                end
                if (tx_d < TO) begin
                    exp_err[tx_c + tx_d + 1] = model_err;
                    for (int k = 1; k <= GAP; k++) exp_busy[tx_c + tx_d + k] = 1'b1;
                    exp_busy[tx_c + tx_d + GAP + 1] = 1'b0;
                    next_start_min = tx_c + tx_d + GAP + 3;
                    repeat (tx_d) @(negedge clk);
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end else begin
                    exp_busy[tx_c + TO - 1] = 1'b1;
                    exp_busy[tx_c + TO]     = 1'b0;
                    exp_err[tx_c + TO]      = 1'b1;
                    model_err      = 1'b1;
                    next_start_min = tx_c + TO + 2;
                    if (tx_d == HANG + 18) begin
                        // Late completion pulse while the arbiter is already back in IDLE.
                        repeat (TO) @(negedge clk);
                        bus.tx_done = 1'b1;
                        @(negedge clk);
                        bus.tx_done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drop_acked();
        for (int i = 0; i < N; i++) begin
            if (bus.req_ack[i]) begin
                if (cont_mode) begin
                    cont_left--;
                    if (cont_left == 0) bus.req_valid = '0;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            drop_acked();
            if (exp_q.size() == 0 && !bus.busy && exp_busy.num() == 0 &&
                exp_err.num() == 0 && !bus.tx_done) break;
        end
        check("wait_bound", 64'(n < 3000), 64'd1);
    endtask

    task automatic wait_start(output int c);
        int n;
        c = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            drop_acked();
            if (bus.tx_start) begin
                c = cyc;
                break;
            end
        end
        check("start_seen", 64'(c >= 0), 64'd1);
    endtask

    // Reference: grant the nearest pending requester at or after the pointer, remove it, advance.
    task automatic model_burst(input logic [N-1:0] mask);
        logic [N-1:0] rem;
        int           p;
        int           idx;
        rem = mask;
        p   = model_ptr;
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = words[i];
        while (rem != '0) begin
            idx = p;
            while (!rem[idx]) idx = (idx + 1) % N;
            exp_q.push_back('{idx, words[idx]});
            rem[idx] = 1'b0;
            p = (idx + 1) % N;
        end
        model_ptr = p;
        bus.req_valid = mask;
    endtask

    task automatic rand_words();
        for (int i = 0; i < N; i++) words[i] = $urandom;
    endtask

    task automatic clear_err();
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(bus.err_timeout), 64'd0);
        model_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(bus.req_ack), 64'd0);
        check("rst_start", 64'(bus.tx_start), 64'd0);
        check("rst_data", 64'(bus.tx_data), 64'd0);
        check("rst_grant", 64'(bus.grant_id), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err_timeout), 64'd0);
        reset = 1'b0;

        // Single request on requester 0.
        force_d = 3;
        rand_words();
        words[0] = 32'hDEADBEEF;
        model_burst(4'b0001);
        wait_idle();

        // Grant to 2 leaves the pointer at 3; then 1001 must go 3 then 0.
        force_d = 2;
        rand_words();
        model_burst(4'b0100);
        wait_idle();
        rand_words();
        model_burst(4'b1001);
        wait_idle();

        // All requesters continuously valid: strict rotation, 8 grants.
        for (int i = 0; i < N; i++) words[i] = 32'h11111111 * (i + 1);
        begin
            int p;
            p = model_ptr;
            for (int g = 0; g < 8; g++) begin
                exp_q.push_back('{p, words[p]});
                p = (p + 1) % N;
            end
            model_ptr = p;
        end
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = words[i];
        cont_mode = 1'b1;
        cont_left = 8;
        bus.req_valid = '1;
        wait_idle();
        cont_mode = 1'b0;

        // A request withdrawn before it could be granted is never acknowledged.
        force_d = 10;
        rand_words();
        model_burst(4'b0001);
        wait_start(c);
        bus.req_valid[2] = 1'b1;
        repeat (3) @(negedge clk);
        bus.req_valid[2] = 1'b0;
        wait_idle();

        // Completion on the same edge as the watchdog expiry: no error.
        force_d = TO - 1;
        rand_words();
        model_burst(4'b0010);
        wait_idle();

        // Hung transmitter, then the next request is still served, then clear.
        force_d = HANG;
        rand_words();
        model_burst(4'b0100);
        wait_idle();
        force_d = 1;
        rand_words();
        model_burst(4'b1000);
        wait_idle();
        clear_err();

        // err_clear on the timeout edge: the set wins.
        force_d = HANG;
        rand_words();
        model_burst(4'b0001);
        wait_start(c);
        while (cyc < c + TO - 1) begin
            @(negedge clk);
            drop_acked();
        end
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        wait_idle();
        check("err_set_wins", 64'(bus.err_timeout), 64'd1);

        // Randomized bursts.
        force_d = -1;
        for (int b = 0; b < 40; b++) begin
            rand_words();
            model_burst(4'($urandom_range(1, 15)));
            wait_idle();
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        // Asynchronous reset while waiting on the transmitter, with the error flag set.
        force_d = HANG;
        rand_words();
        model_burst(4'b0001);
        wait_idle();
        check("err_before_reset", 64'(bus.err_timeout), 64'd1);
        rand_words();
        model_burst(4'b0010);
        wait_start(c);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ack", 64'(bus.req_ack), 64'd0);
        check("arst_start", 64'(bus.tx_start), 64'd0);
        check("arst_data", 64'(bus.tx_data), 64'd0);
        check("arst_grant", 64'(bus.grant_id), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_err", 64'(bus.err_timeout), 64'd0);
        exp_q.delete();
        exp_busy.delete();
        exp_err.delete();
        model_ptr      = 0;
        model_err      = 1'b0;
        cur_word       = 32'd0;
        ack_cyc        = -10;
        next_start_min = 0;
        bus.req_valid  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        force_d = 4;
        rand_words();
        model_burst(4'b1010);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
